// File: rtl/sopc_mem_fill_check_master.sv
// Avalon-MM RAM self-test master: fills a word window with a seed-based pattern,
// reads it back through a fixed-latency pipe, and reports pass, mismatch count and first bad address.
module sopc_mem_fill_check_master #(
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W:0]     num_words,
  input  logic [DATA_W-1:0]   seed,
  input  logic                invert,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [ADDR_W:0]     err_count,
  output logic [ADDR_W-1:0]   first_err_addr,
  output logic [ADDR_W-1:0]   avm_address,
  output logic [DATA_W/8-1:0] avm_byteenable,
  output logic                avm_chipselect,
  output logic                avm_write,
  output logic                avm_read,
  output logic [DATA_W-1:0]   avm_writedata,
  input  logic [DATA_W-1:0]   avm_readdata,
  input  logic                avm_waitrequest
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int RL    = READ_LATENCY;
  localparam int EXP_W = RL * DATA_W;
  localparam int PA_W  = RL * ADDR_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  function automatic logic [DATA_W-1:0] pattern_f(
    input logic [DATA_W-1:0] s,
    input logic [CNT_W-1:0]  i,
    input logic              inv
  );
    logic [DATA_W-1:0] v_s;
    v_s = s + DATA_W'(i);
    return inv ? ~v_s : v_s;
  endfunction

  state_t              state_r;
  logic [ADDR_W-1:0]   base_r;
  logic [CNT_W-1:0]    num_r;
  logic [DATA_W-1:0]   seed_r;
  logic                invert_r;
  logic [CNT_W-1:0]    idx_r;
  logic [DATA_W-1:0]   cur_data_r;

  // Read-compare pipe: stage 0 is the newest entry, the top stage lines up with avm_readdata.
  logic [RL-1:0]       pipe_vld_r;
  logic [EXP_W-1:0]    pipe_exp_r;
  logic [PA_W-1:0]     pipe_addr_r;

  logic                accept_s;
  logic                push_s;
  logic                last_s;
  logic [CNT_W-1:0]    next_idx_s;
  logic [ADDR_W-1:0]   next_addr_s;
  logic [DATA_W-1:0]   next_data_s;
  logic                mismatch_s;
  logic                pipe_empty_s;

  // Transfer acceptance, next-word address/data and compare result.
  always_comb begin
    accept_s     = (avm_write | avm_read) & ~avm_waitrequest;
    push_s       = avm_read & ~avm_waitrequest;
    last_s       = (idx_r == (num_r - CNT_W'(1)));
    next_idx_s   = idx_r + CNT_W'(1);
    next_addr_s  = base_r + next_idx_s[ADDR_W-1:0];
    next_data_s  = pattern_f(seed_r, next_idx_s, invert_r);
    mismatch_s   = pipe_vld_r[RL-1] & (avm_readdata != pipe_exp_r[EXP_W-1 -: DATA_W]);
    pipe_empty_s = (pipe_vld_r == '0);
  end

  // Run sequencer, bus strobes, read pipe and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r        <= IDLE;
      base_r         <= '0;
      num_r          <= '0;
      seed_r         <= '0;
      invert_r       <= 1'b0;
      idx_r          <= '0;
      cur_data_r     <= '0;
      pipe_vld_r     <= '0;
      pipe_exp_r     <= '0;
      pipe_addr_r    <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      avm_address    <= '0;
      avm_byteenable <= '0;
      avm_chipselect <= 1'b0;
      avm_write      <= 1'b0;
      avm_read       <= 1'b0;
      avm_writedata  <= '0;
    end else begin
      done        <= 1'b0;
      pipe_vld_r  <= RL'({pipe_vld_r, push_s});
      pipe_exp_r  <= EXP_W'({pipe_exp_r, cur_data_r});
      pipe_addr_r <= PA_W'({pipe_addr_r, avm_address});

      if (mismatch_s) begin
        if (err_count != '1) begin
          err_count <= err_count + CNT_W'(1);
        end
        if (err_count == '0) begin
          first_err_addr <= pipe_addr_r[PA_W-1 -: ADDR_W];
        end
      end

      case (state_r)
        IDLE: begin
          if (start) begin
            base_r     <= base_addr;
            num_r      <= num_words;
            seed_r     <= seed;
            invert_r   <= invert;
            idx_r      <= '0;
            err_count  <= '0;
            pass       <= 1'b0;
            busy       <= 1'b1;
            cur_data_r <= pattern_f(seed, '0, invert);
            if (num_words == '0) begin
              state_r <= DRAIN;
            end else begin
              state_r        <= WRITE;
              avm_write      <= 1'b1;
              avm_chipselect <= 1'b1;
              avm_byteenable <= '1;
              avm_address    <= base_addr;
              avm_writedata  <= pattern_f(seed, '0, invert);
            end
          end
        end
        WRITE: begin
          if (accept_s) begin
            if (last_s) begin
              // Reads start on the very next clock from the window base.
              state_r       <= READ;
              avm_write     <= 1'b0;
              avm_read      <= 1'b1;
              avm_address   <= base_r;
              avm_writedata <= '0;
              idx_r         <= '0;
              cur_data_r    <= pattern_f(seed_r, '0, invert_r);
            end else begin
              idx_r         <= next_idx_s;
              avm_address   <= next_addr_s;
              avm_writedata <= next_data_s;
              cur_data_r    <= next_data_s;
            end
          end
        end
        READ: begin
          if (accept_s) begin
            if (last_s) begin
              state_r        <= DRAIN;
              avm_read       <= 1'b0;
              avm_chipselect <= 1'b0;
              avm_byteenable <= '0;
              avm_address    <= '0;
            end else begin
              idx_r       <= next_idx_s;
              avm_address <= next_addr_s;
              cur_data_r  <= next_data_s;
            end
          end
        end
        DRAIN: begin
          if (pipe_empty_s) begin
            state_r <= IDLE;
            done    <= 1'b1;
            busy    <= 1'b0;
            pass    <= (err_count == '0);
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sopc_mem_fill_check_master.sv
// Bench for the RAM fill/check master: two instances (read latency 1 and 3) against model RAMs
// with random stall, checked per cycle against a window/pattern model of the run.
module tb_sopc_mem_fill_check_master;

  localparam int AW   = 12;
  localparam int DW   = 32;
  localparam int BW   = DW / 8;
  localparam int LAT0 = 1;
  localparam int LAT1 = 3;
  localparam int TMO  = 40000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   num_words;
  logic [DW-1:0] seed;
  logic          invert;

  logic          busy [2];
  logic          done [2];
  logic          pass [2];
  logic [AW:0]   err_count [2];
  logic [AW-1:0] first_err_addr [2];
  logic [AW-1:0] avm_address [2];
  logic [BW-1:0] avm_byteenable [2];
  logic          avm_chipselect [2];
  logic          avm_write [2];
  logic          avm_read [2];
  logic [DW-1:0] avm_writedata [2];
  logic [DW-1:0] avm_readdata [2];
  logic          avm_waitrequest [2];

  sopc_mem_fill_check_master #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(LAT0)) u_lat1 (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .num_words(num_words),
    .seed(seed), .invert(invert), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .err_count(err_count[0]), .first_err_addr(first_err_addr[0]), .avm_address(avm_address[0]),
    .avm_byteenable(avm_byteenable[0]), .avm_chipselect(avm_chipselect[0]), .avm_write(avm_write[0]),
    .avm_read(avm_read[0]), .avm_writedata(avm_writedata[0]), .avm_readdata(avm_readdata[0]),
    .avm_waitrequest(avm_waitrequest[0])
  );

  sopc_mem_fill_check_master #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(LAT1)) u_lat3 (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .num_words(num_words),
    .seed(seed), .invert(invert), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .err_count(err_count[1]), .first_err_addr(first_err_addr[1]), .avm_address(avm_address[1]),
    .avm_byteenable(avm_byteenable[1]), .avm_chipselect(avm_chipselect[1]), .avm_write(avm_write[1]),
    .avm_read(avm_read[1]), .avm_writedata(avm_writedata[1]), .avm_readdata(avm_readdata[1]),
    .avm_waitrequest(avm_waitrequest[1])
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int start_cyc = 0;
  int done_cnt [2];
  bit in_run [2];
  int wcnt [2];
  int rcnt [2];
  bit stall_q [2];
  logic [AW+DW+1:0] held_q [2];

  logic [AW-1:0] cur_base;
  int            cur_n;
  logic [DW-1:0] cur_seed;
  logic          cur_inv;
  int            exp_err;
  logic [AW-1:0] exp_first;
  bit            fault_en  = 1'b0;
  logic          fault_val = 1'b0;
  bit            wr_rand   = 1'b0;

  logic [DW-1:0] ram [2][4096];
  logic [DW-1:0] rdp [2][4];
  logic [AW-1:0] wlog_a [$];
  logic [DW-1:0] wlog_d [$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic logic [DW-1:0] pat(input logic [DW-1:0] s, input int i, input logic inv);
    logic [DW-1:0] v;
    v = s + DW'(i);
    return inv ? ~v : v;
  endfunction

  // Faulty cells: bit 0 of words 5 and 9 forced to fault_val on read.
  function automatic logic [DW-1:0] slave_rd(input int k, input logic [AW-1:0] a);
    logic [DW-1:0] v;
    v = ram[k][a];
    if (fault_en && (a == 12'd5 || a == 12'd9)) v[0] = fault_val;
    return v;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Model RAM slaves with fixed read latency per instance.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (avm_write[k] && !avm_waitrequest[k]) ram[k][avm_address[k]] <= avm_writedata[k];
      rdp[k][0] <= (avm_read[k] && !avm_waitrequest[k]) ? slave_rd(k, avm_address[k]) : '0;
      for (int j = 1; j < 4; j++) rdp[k][j] <= rdp[k][j-1];
    end
  end
  assign avm_readdata[0] = rdp[0][LAT0-1];
  assign avm_readdata[1] = rdp[1][LAT1-1];

  initial begin
    avm_waitrequest[0] = 1'b0;
    avm_waitrequest[1] = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++)
        avm_waitrequest[k] = wr_rand ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  // Per-cycle compare against the run model.
  initial begin
    logic [AW+DW+1:0] cur_vec;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (reset) begin
          chk("reset_outputs", 64'({busy[k], done[k], pass[k], err_count[k], first_err_addr[k],
              avm_address[k], avm_byteenable[k], avm_chipselect[k], avm_write[k], avm_read[k]}), 64'd0);
          chk("reset_wdata", 64'(avm_writedata[k]), 64'd0);
          in_run[k]  = 1'b0;
          stall_q[k] = 1'b0;
        end else begin
          if (done[k]) begin
            chk("done_expected", 64'(in_run[k]), 64'd1);
            chk("write_count", 64'(wcnt[k]), 64'(cur_n));
            chk("read_count", 64'(rcnt[k]), 64'(cur_n));
            chk("err_count", 64'(err_count[k]), 64'(exp_err));
            chk("pass", 64'(pass[k]), 64'(exp_err == 0));
            if (exp_err > 0) chk("first_err_addr", 64'(first_err_addr[k]), 64'(exp_first));
            if (cur_n == 0) chk("zero_len_latency", 64'(cyc - start_cyc), 64'd2);
            done_cnt[k]++;
            in_run[k] = 1'b0;
          end
          chk("busy", 64'(busy[k]), 64'(in_run[k]));
          chk("rw_exclusive", 64'(avm_write[k] & avm_read[k]), 64'd0);
          chk("chipselect", 64'(avm_chipselect[k]), 64'(avm_write[k] | avm_read[k]));
          chk("byteenable", 64'(avm_byteenable[k]), (avm_write[k] | avm_read[k]) ? 64'hF : 64'h0);
          cur_vec = {avm_address[k], avm_writedata[k], avm_write[k], avm_read[k]};
          if (stall_q[k]) chk("stall_hold", 64'(cur_vec), 64'(held_q[k]));
          if (avm_write[k] && !avm_waitrequest[k]) begin
            chk("write_in_window", 64'(wcnt[k] < cur_n), 64'd1);
            chk("write_addr", 64'(avm_address[k]), 64'(AW'(cur_base + wcnt[k])));
            chk("write_data", 64'(avm_writedata[k]), 64'(pat(cur_seed, wcnt[k], cur_inv)));
            if (k == 0) begin
              wlog_a.push_back(avm_address[k]);
              wlog_d.push_back(avm_writedata[k]);
            end
            wcnt[k]++;
          end
          if (avm_read[k] && !avm_waitrequest[k]) begin
            chk("read_after_writes", 64'(wcnt[k]), 64'(cur_n));
            chk("read_in_window", 64'(rcnt[k] < cur_n), 64'd1);
            chk("read_addr", 64'(avm_address[k]), 64'(AW'(cur_base + rcnt[k])));
            rcnt[k]++;
          end
          stall_q[k] = (avm_write[k] | avm_read[k]) & avm_waitrequest[k];
          held_q[k]  = cur_vec;
          if (start && !in_run[k]) begin
            in_run[k] = 1'b1;
            wcnt[k]   = 0;
            rcnt[k]   = 0;
          end
        end
      end
    end
  end

  task automatic launch(input logic [AW-1:0] b, input int n, input logic [DW-1:0] s,
                        input logic inv, input bit dbl);
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            e;
    logic [AW-1:0] f;
    cur_base = b; cur_n = n; cur_seed = s; cur_inv = inv;
    e = 0; f = '0;
    for (int i = 0; i < n; i++) begin
      a = AW'(b + i);
      d = pat(s, i, inv);
      if (fault_en && (a == 12'd5 || a == 12'd9) && d[0] != fault_val) begin
        if (e == 0) f = a;
        e++;
      end
    end
    exp_err = e; exp_first = f;
    @(posedge clk); #1;
    base_addr = b; num_words = (AW+1)'(n); seed = s; invert = inv; start = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    if (dbl) begin
      base_addr = ~b; num_words = 13'd1; seed = ~s; invert = ~inv;
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic run(input logic [AW-1:0] b, input int n, input logic [DW-1:0] s,
                     input logic inv, input bit dbl);
    int d0, d1, t;
    d0 = done_cnt[0]; d1 = done_cnt[1];
    launch(b, n, s, inv, dbl);
    t = 0;
    while ((done_cnt[0] == d0 || done_cnt[1] == d1) && t < TMO) begin
      @(posedge clk);
      t++;
    end
    chk("run_finished", 64'(t < TMO), 64'd1);
    repeat (4) @(posedge clk);
    #1;
    chk("single_done_lat1", 64'(done_cnt[0] - d0), 64'd1);
    chk("single_done_lat3", 64'(done_cnt[1] - d1), 64'd1);
  endtask

  initial begin
    logic [AW-1:0] ea [4];
    logic [DW-1:0] ed [4];
    int d0, d1, t;
    reset = 1'b1; start = 1'b0; base_addr = '0; num_words = '0; seed = '0; invert = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_pass", 64'(pass[0] | pass[1]), 64'd0);
    chk("reset_busy", 64'(busy[0] | busy[1]), 64'd0);
    reset = 1'b0;

    chk("model_pat_inv", 64'(pat(32'd0, 3, 1'b1)), 64'hFFFFFFFC);
    chk("model_pat", 64'(pat(32'h100, 15, 1'b0)), 64'h10F);

    // Plain fill/check.
    run(12'h000, 16, 32'h100, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      chk("t1_pass", 64'(pass[k]), 64'd1);
      chk("t1_err", 64'(err_count[k]), 64'd0);
    end

    // Bit 0 stuck at 0 at words 5 and 9.
    fault_en = 1'b1; fault_val = 1'b0;
    run(12'h000, 16, 32'h100, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      chk("t2_pass", 64'(pass[k]), 64'd0);
      chk("t2_err", 64'(err_count[k]), 64'd2);
      chk("t2_first", 64'(first_err_addr[k]), 64'd5);
    end
    fault_en = 1'b0;

    // Address wrap with inverted pattern.
    wlog_a.delete(); wlog_d.delete();
    run(12'hFFE, 4, 32'd0, 1'b1, 1'b0);
    ea = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
    ed = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'hFFFFFFFC};
    chk("t3_nwrites", 64'(wlog_a.size()), 64'd4);
    for (int i = 0; i < wlog_a.size() && i < 4; i++) begin
      chk("t3_addr", 64'(wlog_a[i]), 64'(ea[i]));
      chk("t3_data", 64'(wlog_d[i]), 64'(ed[i]));
    end
    chk("t3_pass", 64'(pass[0] & pass[1]), 64'd1);

    // Random stall, then random windows with random faults and ignored re-starts.
    wr_rand = 1'b1;
    run(AW'($urandom), 64, $urandom, 1'($urandom_range(0, 1)), 1'b0);
    chk("t4_pass", 64'(pass[0] & pass[1]), 64'd1);
    for (int r = 0; r < 6; r++) begin
      fault_en  = 1'($urandom_range(0, 1));
      fault_val = 1'($urandom_range(0, 1));
      run(($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 4095)) : AW'($urandom_range(0, 8)),
          $urandom_range(1, 200), $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    wr_rand = 1'b0;

    // Full window from a nonzero base.
    fault_en = 1'b1; fault_val = 1'($urandom_range(0, 1));
    run(12'h123, 4096, $urandom, 1'b0, 1'b0);
    fault_en = 1'b0;

    // Zero-length run with a second start while busy.
    run(12'h010, 0, 32'd0, 1'b0, 1'b1);
    chk("t5_pass", 64'(pass[0] & pass[1]), 64'd1);

    // Reset during READ aborts without done.
    wr_rand = 1'b1;
    d0 = done_cnt[0]; d1 = done_cnt[1];
    launch(12'h000, 64, $urandom, 1'b0, 1'b0);
    t = 0;
    while (!avm_read[0] && t < 2000) begin
      @(posedge clk); #1;
      t++;
    end
    chk("t6_reached_read", 64'(avm_read[0]), 64'd1);
    reset = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("t6_async_clear", 64'({busy[k], done[k], pass[k], err_count[k], first_err_addr[k],
          avm_address[k], avm_byteenable[k], avm_chipselect[k], avm_write[k], avm_read[k]}), 64'd0);
      chk("t6_async_wdata", 64'(avm_writedata[k]), 64'd0);
    end
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("t6_no_done_lat1", 64'(done_cnt[0] - d0), 64'd0);
    chk("t6_no_done_lat3", 64'(done_cnt[1] - d1), 64'd0);
    run(12'h040, 8, $urandom, 1'b1, 1'b0);
    chk("t6_pass", 64'(pass[0] & pass[1]), 64'd1);
    wr_rand = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
